// File: rtl/dshot_pkg.sv
// DShot receiver shared definitions: FSM states, timing
// constant helpers and the throttle/command boundary.
package dshot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_CHECK
    } state_t;

    // Frame values below this are commands, not throttle.
    localparam logic [10:0] CMD_LIMIT = 11'd48;

    // Bit period in clocks and the windows derived from it.
    function automatic int calc_t(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    function automatic int calc_thr(input int t);
        return t / 2;
    endfunction

    function automatic int calc_hmin(input int t);
        return t / 8;
    endfunction

    function automatic int calc_hmax(input int t);
        return (7 * t) / 8;
    endfunction

    function automatic int calc_pmin(input int t);
        return (3 * t) / 4;
    endfunction

    function automatic int calc_pmax(input int t);
        return (5 * t) / 4;
    endfunction

    function automatic int calc_gap(input int t);
        return 2 * t;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dshot_crc.sv
// DShot checksum: XOR of the three payload nibbles,
// complemented on bidirectional links.
module dshot_crc #(
    parameter int INVERTED = 0
) (
    input  logic [15:0] frame,
    output logic        match
);

    logic [3:0] crc;

    // Nibble XOR over frame[15:4], compared with frame[3:0].
    always_comb begin
        crc = frame[15:12] ^ frame[11:8] ^ frame[7:4];
        if (INVERTED != 0) begin
            crc = ~crc;
        end
        match = (crc == frame[3:0]);
    end

endmodule

// File: rtl/dshot_rx.sv
// DShot frame receiver: measures pulse widths on the
// synchronized line, assembles 16 bits and checks the CRC.
module dshot_rx
    import dshot_pkg::*;
#(
    parameter int CLK_HZ   = 16000000,
    parameter int BIT_RATE = 150000,
    parameter int INVERTED = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_pin,
    output logic        frame_valid,
    output logic [15:0] raw_frame,
    output logic [10:0] throttle,
    output logic [5:0]  command,
    output logic        is_command,
    output logic        telemetry_req,
    output logic        crc_error,
    output logic        frame_error,
    output logic [7:0]  crc_err_count,
    output logic [7:0]  frame_err_count,
    output logic        busy
);

    localparam int T    = calc_t(CLK_HZ, BIT_RATE);
    localparam int THR  = calc_thr(T);
    localparam int HMIN = calc_hmin(T);
    localparam int HMAX = calc_hmax(T);
    localparam int PMIN = calc_pmin(T);
    localparam int PMAX = calc_pmax(T);
    localparam int GAP  = calc_gap(T);
    localparam int CW   = $clog2(GAP + 1);

    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_THR  = CW'(THR);
    localparam logic [CW-1:0] C_HMIN = CW'(HMIN);
    localparam logic [CW-1:0] C_HMAX = CW'(HMAX);
    localparam logic [CW-1:0] C_PMIN = CW'(PMIN);
    localparam logic [CW-1:0] C_PMAX = CW'(PMAX);
    localparam logic [CW-1:0] C_GAP1 = CW'(GAP - 1);
    localparam logic          INV    = (INVERTED != 0);

    logic          sync1;
    logic          sync2;
    logic          line_q;
    logic          line;
    logic          rise;
    logic          fall;
    logic          low_long;
    logic          crc_ok;
    logic          armed;
    state_t        state;
    logic [CW-1:0] high_cnt;
    logic [CW-1:0] per_cnt;
    logic [CW-1:0] low_cnt;
    logic [4:0]    bit_cnt;
    logic [15:0]   shreg;

    assign line     = sync2 ^ INV;
    assign rise     = line & ~line_q;
    assign fall     = ~line & line_q;
    assign low_long = ~line & (low_cnt >= C_GAP1);
    assign busy     = (state != ST_IDLE);

    dshot_crc #(
        .INVERTED(INVERTED)
    ) u_crc (
        .frame(shreg),
        .match(crc_ok)
    );

    // Two-flop synchronizer plus delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= INV;
            sync2  <= INV;
            line_q <= 1'b0;
        end else begin
            sync1  <= in_pin;
            sync2  <= sync1;
            line_q <= line;
        end
    end

    // Consecutive low-line cycles, used for gap and resync.
    always_ff @(posedge clk) begin
        if (reset) begin
            low_cnt <= '0;
        end else if (line) begin
            low_cnt <= '0;
        end else if (low_cnt != '1) begin
            low_cnt <= low_cnt + C_ONE;
        end
    end

    // Frame FSM with registered outputs, strobes and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            armed           <= 1'b1;
            high_cnt        <= '0;
            per_cnt         <= '0;
            bit_cnt         <= '0;
            shreg           <= '0;
            frame_valid     <= 1'b0;
            crc_error       <= 1'b0;
            frame_error     <= 1'b0;
            raw_frame       <= '0;
            throttle        <= '0;
            command         <= '0;
            is_command      <= 1'b0;
            telemetry_req   <= 1'b0;
            crc_err_count   <= '0;
            frame_err_count <= '0;
        end else begin
            frame_valid <= 1'b0;
            crc_error   <= 1'b0;
            frame_error <= 1'b0;
            if (high_cnt != '1) high_cnt <= high_cnt + C_ONE;
            if (per_cnt != '1) per_cnt <= per_cnt + C_ONE;
            unique case (state)
                ST_IDLE: begin
                    if (low_long) armed <= 1'b1;
                    if (rise && armed) begin
                        bit_cnt  <= '0;
                        shreg    <= '0;
                        high_cnt <= C_ONE;
                        per_cnt  <= C_ONE;
                        state    <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        if (high_cnt < C_HMIN || high_cnt > C_HMAX) begin
                            frame_error     <= 1'b1;
                            frame_err_count <= sat_inc(frame_err_count);
                            armed           <= 1'b0;
                            state           <= ST_IDLE;
                        end else begin
                            shreg   <= {shreg[14:0], high_cnt > C_THR};
                            bit_cnt <= bit_cnt + 5'd1;
                            state   <= (bit_cnt == 5'd15) ? ST_CHECK : ST_LOW;
                        end
                    end else if (high_cnt >= C_HMAX) begin
                        frame_error     <= 1'b1;
                        frame_err_count <= sat_inc(frame_err_count);
                        armed           <= 1'b0;
                        state           <= ST_IDLE;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        if (per_cnt < C_PMIN || per_cnt > C_PMAX) begin
                            frame_error     <= 1'b1;
                            frame_err_count <= sat_inc(frame_err_count);
                            armed           <= 1'b0;
                            state           <= ST_IDLE;
                        end else begin
                            high_cnt <= C_ONE;
                            per_cnt  <= C_ONE;
                            state    <= ST_HIGH;
                        end
                    end else if (low_long) begin
                        frame_error     <= 1'b1;
                        frame_err_count <= sat_inc(frame_err_count);
                        armed           <= 1'b0;
                        state           <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (crc_ok) begin
                        frame_valid   <= 1'b1;
                        raw_frame     <= shreg;
                        telemetry_req <= shreg[4];
                        if (shreg[15:5] < CMD_LIMIT) begin
                            is_command <= 1'b1;
                            command    <= shreg[10:5];
                            throttle   <= '0;
                        end else begin
                            is_command <= 1'b0;
                            command    <= '0;
                            throttle   <= shreg[15:5] - CMD_LIMIT;
                        end
                    end else begin
                        crc_error     <= 1'b1;
                        crc_err_count <= sat_inc(crc_err_count);
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dshot_rx.sv
// Self-checking bench for dshot_rx: plain, bidirectional and
// fast bidirectional instances driven by a bit-level line model.
module tb_dshot_rx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pin_a = 1'b0;
    logic pin_b = 1'b1;
    logic pin_c = 1'b1;

    logic        fv_a, isc_a, tel_a, ce_a, fe_a, busy_a;
    logic [15:0] raw_a;
    logic [10:0] thr_a;
    logic [5:0]  cmd_a;
    logic [7:0]  cec_a, fec_a;

    logic        fv_b, isc_b, tel_b, ce_b, fe_b, busy_b;
    logic [15:0] raw_b;
    logic [10:0] thr_b;
    logic [5:0]  cmd_b;
    logic [7:0]  cec_b, fec_b;

    logic        fv_c, isc_c, tel_c, ce_c, fe_c, busy_c;
    logic [15:0] raw_c;
    logic [10:0] thr_c;
    logic [5:0]  cmd_c;
    logic [7:0]  cec_c, fec_c;

    int cmp = 0;
    int bad = 0;
    int va = 0, ca = 0, fa = 0;
    int vb = 0, cb = 0;
    int vc = 0, cc = 0;

    logic [15:0] m_raw = 16'h0000;
    int m_nv = 0, m_nc = 0, m_nf = 0;
    int m_crc = 0, m_frm = 0;

    always #5 clk = ~clk;

    dshot_rx u_a (
        .clk(clk), .reset(reset), .in_pin(pin_a),
        .frame_valid(fv_a), .raw_frame(raw_a), .throttle(thr_a),
        .command(cmd_a), .is_command(isc_a), .telemetry_req(tel_a),
        .crc_error(ce_a), .frame_error(fe_a),
        .crc_err_count(cec_a), .frame_err_count(fec_a), .busy(busy_a)
    );

    dshot_rx #(.INVERTED(1)) u_b (
        .clk(clk), .reset(reset), .in_pin(pin_b),
        .frame_valid(fv_b), .raw_frame(raw_b), .throttle(thr_b),
        .command(cmd_b), .is_command(isc_b), .telemetry_req(tel_b),
        .crc_error(ce_b), .frame_error(fe_b),
        .crc_err_count(cec_b), .frame_err_count(fec_b), .busy(busy_b)
    );

    dshot_rx #(.BIT_RATE(1200000), .INVERTED(1)) u_c (
        .clk(clk), .reset(reset), .in_pin(pin_c),
        .frame_valid(fv_c), .raw_frame(raw_c), .throttle(thr_c),
        .command(cmd_c), .is_command(isc_c), .telemetry_req(tel_c),
        .crc_error(ce_c), .frame_error(fe_c),
        .crc_err_count(cec_c), .frame_err_count(fec_c), .busy(busy_c)
    );

    // Strobe counters observed away from the active edge.
    always @(negedge clk) begin
        if (fv_a) va++;
        if (ce_a) ca++;
        if (fe_a) fa++;
        if (fv_b) vb++;
        if (ce_b) cb++;
        if (fv_c) vc++;
        if (ce_c) cc++;
    end

    task automatic set_line(input int which, input logic lvl);
        case (which)
            0:       pin_a = lvl;
            1:       pin_b = ~lvl;
            default: pin_c = ~lvl;
        endcase
    endtask

    task automatic idle(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(which, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic send_bits(input int which, input logic [15:0] f,
                             input int hi, input int lo, input int t,
                             input int h1, input int h0);
        for (int i = hi; i >= lo; i--) begin
            for (int c = 0; c < t; c++) begin
                set_line(which, c < (f[i] ? h1 : h0));
                @(negedge clk);
            end
        end
    endtask

    task automatic send_slow(input int which, input logic [15:0] f);
        send_bits(which, f, 15, 0, 106, 80, 40);
        idle(which, 60);
    endtask

    task automatic send_fast(input logic [15:0] f);
        send_bits(2, f, 15, 0, 13, 10, 4);
        idle(2, 4);
    endtask

    // Reference: checksum is the XOR of the three payload nibbles.
    task automatic model_a(input logic [15:0] f);
        if (f[3:0] == (f[15:12] ^ f[11:8] ^ f[7:4])) begin
            m_nv++;
            m_raw = f;
        end else begin
            m_nc++;
            if (m_crc < 255) m_crc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        cmp++;
        if ({raw_a, thr_a, cmd_a, isc_a, tel_a, cec_a, fec_a} !== 54'h0) begin
            bad++;
            $display("FAIL reset_outputs_a: got %h want 0",
                     {raw_a, thr_a, cmd_a, isc_a, tel_a, cec_a, fec_a});
        end
        cmp++;
        if ({fv_a, ce_a, fe_a, busy_a} !== 4'b0) begin
            bad++;
            $display("FAIL reset_strobes_a: got %b want 0000",
                     {fv_a, ce_a, fe_a, busy_a});
        end
        cmp++;
        if ({raw_b, cec_b, busy_b, raw_c, busy_c} !== 42'h0) begin
            bad++;
            $display("FAIL reset_outputs_bc: got %h want 0",
                     {raw_b, cec_b, busy_b, raw_c, busy_c});
        end
        reset = 1'b0;
        idle(0, 20);
    endtask

    task automatic test_valid;
        send_bits(0, 16'h82C6, 15, 8, 106, 80, 40);
        cmp++;
        if (busy_a !== 1'b1) begin
            bad++;
            $display("FAIL busy_mid: got %b want 1", busy_a);
        end
        send_bits(0, 16'h82C6, 7, 0, 106, 80, 40);
        idle(0, 60);
        model_a(16'h82C6);
        cmp++;
        if (va !== m_nv) begin
            bad++;
            $display("FAIL valid_count: got %0d want %0d", va, m_nv);
        end
        cmp++;
        if (raw_a !== 16'h82C6 || thr_a !== 11'd998) begin
            bad++;
            $display("FAIL valid_decode: got raw %h thr %0d want 82c6 998",
                     raw_a, thr_a);
        end
        cmp++;
        if ({isc_a, tel_a, cec_a, fec_a, busy_a} !== 19'h0) begin
            bad++;
            $display("FAIL valid_flags: got %h want 0",
                     {isc_a, tel_a, cec_a, fec_a, busy_a});
        end
    endtask

    task automatic test_command;
        send_slow(0, 16'h0033);
        model_a(16'h0033);
        cmp++;
        if (va !== m_nv || raw_a !== 16'h0033) begin
            bad++;
            $display("FAIL cmd_frame: got cnt %0d raw %h want %0d 0033",
                     va, raw_a, m_nv);
        end
        cmp++;
        if ({isc_a, cmd_a, tel_a, thr_a} !== {1'b1, 6'd1, 1'b1, 11'd0}) begin
            bad++;
            $display("FAIL cmd_decode: got isc %b cmd %0d tel %b thr %0d want 1 1 1 0",
                     isc_a, cmd_a, tel_a, thr_a);
        end
        send_slow(0, 16'h82C6);
        model_a(16'h82C6);
    endtask

    task automatic test_crc_error;
        send_slow(0, 16'h82C7);
        model_a(16'h82C7);
        cmp++;
        if (ca !== m_nc || cec_a !== 8'(m_crc)) begin
            bad++;
            $display("FAIL crc_err: got strobes %0d cnt %0d want %0d %0d",
                     ca, cec_a, m_nc, m_crc);
        end
        cmp++;
        if (raw_a !== 16'h82C6 || va !== m_nv) begin
            bad++;
            $display("FAIL crc_hold: got raw %h valid %0d want 82c6 %0d",
                     raw_a, va, m_nv);
        end
    endtask

    task automatic test_frame_error;
        send_bits(0, 16'h82C6, 15, 8, 106, 80, 40);
        idle(0, 300);
        m_nf++;
        m_frm++;
        cmp++;
        if (fa !== m_nf || fec_a !== 8'(m_frm) || va !== m_nv) begin
            bad++;
            $display("FAIL frame_err: got %0d cnt %0d valid %0d want %0d %0d %0d",
                     fa, fec_a, va, m_nf, m_frm, m_nv);
        end
        send_slow(0, 16'h0033);
        model_a(16'h0033);
        cmp++;
        if (va !== m_nv || raw_a !== 16'h0033) begin
            bad++;
            $display("FAIL after_frame_err: got %0d raw %h want %0d 0033",
                     va, raw_a, m_nv);
        end
    endtask

    task automatic test_reset_mid;
        send_bits(0, 16'h82C6, 15, 6, 106, 80, 40);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        m_raw = 16'h0000;
        m_crc = 0;
        m_frm = 0;
        cmp++;
        if ({raw_a, thr_a, cmd_a, isc_a, tel_a, cec_a, fec_a, busy_a} !== 55'h0) begin
            bad++;
            $display("FAIL reset_mid_out: got %h want 0",
                     {raw_a, thr_a, cmd_a, isc_a, tel_a, cec_a, fec_a, busy_a});
        end
        cmp++;
        if (va !== m_nv || ca !== m_nc || fa !== m_nf) begin
            bad++;
            $display("FAIL reset_mid_strobe: got %0d/%0d/%0d want %0d/%0d/%0d",
                     va, ca, fa, m_nv, m_nc, m_nf);
        end
        reset = 1'b0;
        idle(0, 50);
        send_slow(0, 16'h82C6);
        model_a(16'h82C6);
        cmp++;
        if (va !== m_nv || raw_a !== 16'h82C6 || thr_a !== 11'd998) begin
            bad++;
            $display("FAIL reset_mid_next: got %0d raw %h thr %0d want %0d 82c6 998",
                     va, raw_a, thr_a, m_nv);
        end
    endtask

    task automatic check_decode_frame(input logic [15:0] f, input string tag);
        int top;
        int e_thr;
        int e_cmd;
        logic e_is;
        send_slow(0, f);
        model_a(f);
        top   = int'(m_raw[15:5]);
        e_is  = (top < 48);
        e_thr = e_is ? 0 : top - 48;
        e_cmd = e_is ? top : 0;
        cmp++;
        if (va !== m_nv || ca !== m_nc || raw_a !== m_raw || cec_a !== 8'(m_crc)) begin
            bad++;
            $display("FAIL %s_frame: got v%0d c%0d raw %h cnt %0d want v%0d c%0d raw %h cnt %0d",
                     tag, va, ca, raw_a, cec_a, m_nv, m_nc, m_raw, m_crc);
        end
        cmp++;
        if (thr_a !== 11'(e_thr) || cmd_a !== 6'(e_cmd) ||
            isc_a !== e_is || tel_a !== m_raw[4]) begin
            bad++;
            $display("FAIL %s_decode: got thr %0d cmd %0d isc %b tel %b want %0d %0d %b %b",
                     tag, thr_a, cmd_a, isc_a, tel_a, e_thr, e_cmd, e_is, m_raw[4]);
        end
    endtask

    task automatic test_boundary;
        int tops[3] = '{48, 47, 2047};
        logic [11:0] d;
        logic [3:0]  crc;
        for (int i = 0; i < 3; i++) begin
            d   = {11'(tops[i]), 1'($urandom_range(0, 1))};
            crc = d[11:8] ^ d[7:4] ^ d[3:0];
            check_decode_frame({d, crc}, "boundary");
        end
    endtask

    task automatic test_random;
        logic [11:0] d;
        logic [3:0]  crc;
        for (int i = 0; i < 6; i++) begin
            d   = 12'($urandom_range(0, 4095));
            crc = d[11:8] ^ d[7:4] ^ d[3:0];
            if ($urandom_range(0, 2) == 0) crc = crc ^ 4'($urandom_range(1, 15));
            check_decode_frame({d, crc}, "random");
        end
    endtask

    task automatic test_inverted;
        send_slow(1, 16'h82C9);
        cmp++;
        if (vb !== 1 || raw_b !== 16'h82C9 || thr_b !== 11'd998) begin
            bad++;
            $display("FAIL inv_valid: got %0d raw %h thr %0d want 1 82c9 998",
                     vb, raw_b, thr_b);
        end
        send_slow(1, 16'h82C6);
        cmp++;
        if (cb !== 1 || cec_b !== 8'd1 || raw_b !== 16'h82C9) begin
            bad++;
            $display("FAIL inv_crc: got %0d cnt %0d raw %h want 1 1 82c9",
                     cb, cec_b, raw_b);
        end
    endtask

    task automatic test_saturation;
        for (int k = 0; k < 256; k++) begin
            send_fast(16'h82C6);
            if (k == 199) begin
                cmp++;
                if (cec_c !== 8'd200) begin
                    bad++;
                    $display("FAIL sat_mid: got %0d want 200", cec_c);
                end
            end
        end
        cmp++;
        if (cc !== 256 || cec_c !== 8'd255 || vc !== 0) begin
            bad++;
            $display("FAIL sat_end: got strobes %0d cnt %0d valid %0d want 256 255 0",
                     cc, cec_c, vc);
        end
        send_fast(16'h82C9);
        cmp++;
        if (vc !== 1 || raw_c !== 16'h82C9 || thr_c !== 11'd998) begin
            bad++;
            $display("FAIL fast_valid: got %0d raw %h thr %0d want 1 82c9 998",
                     vc, raw_c, thr_c);
        end
    endtask

    initial begin
        test_reset;
        test_valid;
        test_command;
        test_crc_error;
        test_frame_error;
        test_reset_mid;
        test_boundary;
        test_random;
        test_inverted;
        test_saturation;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
